// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for wb_bus_arbiter: instruction and data Wishbone slave ports plus the shared master port.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory view.
interface wb_bus_arbiter_if;
  logic        iwbs_cyc_i;
  logic        iwbs_stb_i;
  logic [31:0] iwbs_addr_i;
  logic [31:0] iwbs_dat_o;
  logic        iwbs_ack_o;
  logic        iwbs_err_o;

  logic        dwbs_cyc_i;
  logic        dwbs_stb_i;
  logic        dwbs_we_i;
  logic [3:0]  dwbs_sel_i;
  logic [31:0] dwbs_addr_i;
  logic [31:0] dwbs_dat_i;
  logic [31:0] dwbs_dat_o;
  logic        dwbs_ack_o;
  logic        dwbs_err_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport slave (
    input  iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
    output iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
    input  dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
    output dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport master (
    output iwbs_cyc_i, iwbs_stb_i, iwbs_addr_i,
    input  iwbs_dat_o, iwbs_ack_o, iwbs_err_o,
    output dwbs_cyc_i, dwbs_stb_i, dwbs_we_i, dwbs_sel_i, dwbs_addr_i, dwbs_dat_i,
    input  dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic bus between instruction and data masters,
// with grant locking for the whole cycle and a per-transfer timeout that forces an error.
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic              last_gnt_q;  // 0 = instruction, 1 = data
  logic [TMO_W-1:0]  tmo_cnt_q;

  logic gnt_cyc;
  logic term;
  logic tmo_hit;

  always_comb begin
    gnt_cyc = 1'b0;
    if (state_q == GNT_I) gnt_cyc = bus.iwbs_cyc_i;
    if (state_q == GNT_D) gnt_cyc = bus.dwbs_cyc_i;
    term    = bus.wbm_ack_i | bus.wbm_err_i;
    tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (tmo_cnt_q == TMO_LAST) && !term;
  end

  // Routing is combinational from the registered grant; IDLE drives everything low.
  always_comb begin
    bus.wbm_cyc_o  = 1'b0;
    bus.wbm_stb_o  = 1'b0;
    bus.wbm_we_o   = 1'b0;
    bus.wbm_sel_o  = '0;
    bus.wbm_addr_o = '0;
    bus.wbm_dat_o  = '0;
    bus.iwbs_dat_o = '0;
    bus.iwbs_ack_o = 1'b0;
    bus.iwbs_err_o = 1'b0;
    bus.dwbs_dat_o = '0;
    bus.dwbs_ack_o = 1'b0;
    bus.dwbs_err_o = 1'b0;
    case (state_q)
      GNT_I: begin
        bus.wbm_cyc_o  = bus.iwbs_cyc_i & ~tmo_hit;
        bus.wbm_stb_o  = bus.iwbs_stb_i & ~tmo_hit;
        bus.wbm_sel_o  = '1;
        bus.wbm_addr_o = bus.iwbs_addr_i;
        bus.iwbs_dat_o = bus.wbm_dat_i;
        bus.iwbs_ack_o = bus.wbm_ack_i;
        bus.iwbs_err_o = bus.wbm_err_i | tmo_hit;
      end
      GNT_D: begin
        bus.wbm_cyc_o  = bus.dwbs_cyc_i & ~tmo_hit;
        bus.wbm_stb_o  = bus.dwbs_stb_i & ~tmo_hit;
        bus.wbm_we_o   = bus.dwbs_we_i;
        bus.wbm_sel_o  = bus.dwbs_sel_i;
        bus.wbm_addr_o = bus.dwbs_addr_i;
        bus.wbm_dat_o  = bus.dwbs_dat_i;
        bus.dwbs_dat_o = bus.wbm_dat_i;
        bus.dwbs_ack_o = bus.wbm_ack_i;
        bus.dwbs_err_o = bus.wbm_err_i | tmo_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (bus.iwbs_cyc_i && bus.dwbs_cyc_i)
            state_q <= last_gnt_q ? GNT_I : GNT_D;
          else if (bus.iwbs_cyc_i)
            state_q <= GNT_I;
          else if (bus.dwbs_cyc_i)
            state_q <= GNT_D;
        end
        GNT_I, GNT_D: begin
          if (term || !gnt_cyc || tmo_hit) begin
            state_q    <= IDLE;
            last_gnt_q <= (state_q == GNT_D);
            tmo_cnt_q  <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_wb_bus_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_arbiter_if bus();

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus (0 none, 1 instr, 2 data), cycles waited, who went last.
  int owner      = 0;
  int wait_cnt   = 0;
  bit last_was_d = 1'b0;

  logic        e_cyc, e_stb, e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdat, e_idat, e_ddat;
  logic        e_iack, e_ierr, e_dack, e_derr;

  function automatic bit timed_out();
    return (owner != 0) && (TMO != 0) && (wait_cnt == TMO - 1) && !(bus.wbm_ack_i || bus.wbm_err_i);
  endfunction

  task automatic model_outputs();
    bit to;
    to = timed_out();
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdat = 0;
    e_idat = 0; e_iack = 0; e_ierr = 0; e_ddat = 0; e_dack = 0; e_derr = 0;
    if (owner == 1) begin
      e_cyc  = bus.iwbs_cyc_i && !to;
      e_stb  = bus.iwbs_stb_i && !to;
      e_sel  = 4'hF;
      e_addr = bus.iwbs_addr_i;
      e_idat = bus.wbm_dat_i;
      e_iack = bus.wbm_ack_i;
      e_ierr = bus.wbm_err_i || to;
    end else if (owner == 2) begin
      e_cyc  = bus.dwbs_cyc_i && !to;
      e_stb  = bus.dwbs_stb_i && !to;
      e_we   = bus.dwbs_we_i;
      e_sel  = bus.dwbs_sel_i;
      e_addr = bus.dwbs_addr_i;
      e_wdat = bus.dwbs_dat_i;
      e_ddat = bus.wbm_dat_i;
      e_dack = bus.wbm_ack_i;
      e_derr = bus.wbm_err_i || to;
    end
  endtask

  task automatic model_advance();
    bit done;
    if (rst) begin
      owner = 0; wait_cnt = 0; last_was_d = 1'b0;
    end else if (owner == 0) begin
      if (bus.iwbs_cyc_i && bus.dwbs_cyc_i) owner = last_was_d ? 1 : 2;
      else if (bus.iwbs_cyc_i)              owner = 1;
      else if (bus.dwbs_cyc_i)              owner = 2;
      wait_cnt = 0;
    end else begin
      done = bus.wbm_ack_i || bus.wbm_err_i || timed_out() ||
             !((owner == 1) ? bus.iwbs_cyc_i : bus.dwbs_cyc_i);
      if (done) begin
        last_was_d = (owner == 2);
        owner = 0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_cycle();
    @(negedge clk);
    model_outputs();
    chk("wbm_ctl",  {25'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o},
                    {25'd0, e_cyc, e_stb, e_we, e_sel});
    chk("wbm_addr", bus.wbm_addr_o, e_addr);
    chk("wbm_wdat", bus.wbm_dat_o, e_wdat);
    chk("i_resp",   {30'd0, bus.iwbs_ack_o, bus.iwbs_err_o}, {30'd0, e_iack, e_ierr});
    chk("i_dat",    bus.iwbs_dat_o, e_idat);
    chk("d_resp",   {30'd0, bus.dwbs_ack_o, bus.dwbs_err_o}, {30'd0, e_dack, e_derr});
    chk("d_dat",    bus.dwbs_dat_o, e_ddat);
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  task automatic idle_inputs();
    bus.iwbs_cyc_i = 0; bus.iwbs_stb_i = 0; bus.iwbs_addr_i = '0;
    bus.dwbs_cyc_i = 0; bus.dwbs_stb_i = 0; bus.dwbs_we_i = 0;
    bus.dwbs_sel_i = '0; bus.dwbs_addr_i = '0; bus.dwbs_dat_i = '0;
    bus.wbm_dat_i = '0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;
  endtask

  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h8000_0200;

  initial begin
    logic [31:0] t2_addr [6];
    logic        t4_cyc  [6];
    logic        t4_err  [6];
    t2_addr = '{32'h0, DA, 32'h0, IA, 32'h0, DA};
    t4_cyc  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t4_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    idle_inputs();
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    check_cycle();
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    advance();

    // T1: single data read
    bus.dwbs_cyc_i = 1; bus.dwbs_stb_i = 1; bus.dwbs_addr_i = 32'h8000_0100; bus.dwbs_sel_i = 4'hF;
    check_cycle(); chk("t1_req_cyc", bus.wbm_cyc_o, 0); advance();
    check_cycle(); chk("t1_gnt_cyc", bus.wbm_cyc_o, 1); chk("t1_addr", bus.wbm_addr_o, 32'h8000_0100); advance();
    bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'hDEAD_BEEF;
    check_cycle();
    chk("t1_dack", bus.dwbs_ack_o, 1);
    chk("t1_ddat", bus.dwbs_dat_o, 32'hDEAD_BEEF);
    chk("t1_iack", bus.iwbs_ack_o, 0);
    advance();
    idle_inputs();
    tick();

    // T2: ties after reset alternate D, I, D with one idle cycle between grants
    rst = 1'b1; tick(); rst = 1'b0;
    bus.iwbs_cyc_i = 1; bus.iwbs_stb_i = 1; bus.iwbs_addr_i = IA;
    bus.dwbs_cyc_i = 1; bus.dwbs_stb_i = 1; bus.dwbs_we_i = 1; bus.dwbs_sel_i = 4'h3;
    bus.dwbs_addr_i = DA; bus.dwbs_dat_i = 32'h1234_5678;
    bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'hCAFE_0001;
    for (int k = 0; k < 6; k++) begin
      check_cycle();
      chk("t2_addr", bus.wbm_addr_o, t2_addr[k]);
      advance();
    end
    idle_inputs();
    tick();

    // T3: back-to-back fetches, zero-wait ack
    bus.iwbs_cyc_i = 1; bus.iwbs_stb_i = 1; bus.iwbs_addr_i = IA;
    bus.dwbs_we_i = 1; bus.dwbs_sel_i = 4'h3; bus.dwbs_dat_i = 32'h5555_AAAA;
    bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      check_cycle();
      chk("t3_cyc", bus.wbm_cyc_o, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) begin
        chk("t3_sel", bus.wbm_sel_o, 4'hF);
        chk("t3_we", bus.wbm_we_o, 0);
        chk("t3_wdat", bus.wbm_dat_o, 0);
        chk("t3_iack", bus.iwbs_ack_o, 1);
      end
      advance();
    end
    idle_inputs();
    tick();

    // T4: timeout forces an error in the fourth granted cycle
    bus.dwbs_cyc_i = 1; bus.dwbs_stb_i = 1; bus.dwbs_addr_i = DA; bus.dwbs_sel_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      check_cycle();
      chk("t4_cyc", bus.wbm_cyc_o, t4_cyc[k]);
      chk("t4_derr", bus.dwbs_err_o, t4_err[k]);
      advance();
    end
    idle_inputs();
    tick();
    tick();

    // T5: instruction abort releases the bus; pending data granted afterwards
    bus.iwbs_cyc_i = 1; bus.iwbs_stb_i = 1; bus.iwbs_addr_i = IA;
    tick();
    bus.dwbs_cyc_i = 1; bus.dwbs_stb_i = 1; bus.dwbs_addr_i = DA; bus.dwbs_sel_i = 4'hF;
    check_cycle(); chk("t5_gnt_i", bus.wbm_cyc_o, 1); advance();
    bus.iwbs_cyc_i = 0; bus.iwbs_stb_i = 0;
    check_cycle(); chk("t5_abort_cyc", bus.wbm_cyc_o, 0); chk("t5_abort_ack", bus.iwbs_ack_o, 0); advance();
    check_cycle(); chk("t5_idle_cyc", bus.wbm_cyc_o, 0); advance();
    check_cycle(); chk("t5_gnt_d", bus.wbm_cyc_o, 1); chk("t5_addr", bus.wbm_addr_o, DA); advance();
    bus.wbm_ack_i = 1;
    tick();
    idle_inputs();
    tick();

    // T6: reset during a data wait
    bus.dwbs_cyc_i = 1; bus.dwbs_stb_i = 1; bus.dwbs_addr_i = DA; bus.dwbs_sel_i = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wbm_ack_i = 1; bus.wbm_dat_i = 32'h7777_7777;
    bus.iwbs_cyc_i = 1; bus.iwbs_stb_i = 1; bus.iwbs_addr_i = IA;
    check_cycle();
    chk("t6_cyc", bus.wbm_cyc_o, 0);
    chk("t6_dack", bus.dwbs_ack_o, 0);
    chk("t6_ddat", bus.dwbs_dat_o, 0);
    advance();
    check_cycle(); chk("t6_tie_d", bus.wbm_addr_o, DA); advance();
    idle_inputs();
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      bus.iwbs_cyc_i   = ($urandom_range(0, 3) != 0);
      bus.iwbs_stb_i   = ($urandom_range(0, 3) != 0);
      bus.iwbs_addr_i  = $urandom;
      bus.dwbs_cyc_i   = ($urandom_range(0, 3) != 0);
      bus.dwbs_stb_i   = ($urandom_range(0, 3) != 0);
      bus.dwbs_we_i    = ($urandom_range(0, 1) != 0);
      bus.dwbs_sel_i   = 4'($urandom_range(0, 15));
      bus.dwbs_addr_i  = $urandom;
      bus.dwbs_dat_i   = $urandom;
      bus.wbm_dat_i    = $urandom;
      bus.wbm_ack_i    = ($urandom_range(0, 3) == 0);
      bus.wbm_err_i    = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
